scramble_move_generator: RTL and testbench

Pseudo-random move source that answers the puzzle controller's `RandomPlease` request. On each request it emits exactly `RAND_NUM` legal move codes over a valid/ready handshake, then signals completion. It sits between the shuffle/solve state logic (requester) and the move-execution datapath (consumer). Randomness comes from a 16-bit Fibonacci LFSR.

---
 rtl/scramble_pkg.sv | 31 +++
 rtl/scramble_move_generator_if.sv | 38 +++
 rtl/scramble_move_generator_lfsr16.sv | 38 +++
 rtl/scramble_move_generator.sv | 179 +++++++++++++++++
 tb/tb_scramble_move_generator.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/scramble_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : scramble_pkg
//  Purpose  : Shared FSM states, LFSR width, tap positions and step function
//             for the scramble move generator.
//  Revision : 1.0 - initial release
// ============================================================================
package scramble_pkg;

  localparam int LFSR_W     = 16;
  localparam int LFSR_TAP_A = 15;
  localparam int LFSR_TAP_B = 13;
  localparam int LFSR_TAP_C = 12;
  localparam int LFSR_TAP_D = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    GEN   = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // One Fibonacci step of x^16+x^14+x^13+x^11+1, shifting left.
  function automatic logic [LFSR_W-1:0] lfsrNext(input logic [LFSR_W-1:0] cur);
    return {cur[LFSR_W-2:0],
            cur[LFSR_TAP_A] ^ cur[LFSR_TAP_B] ^ cur[LFSR_TAP_C] ^ cur[LFSR_TAP_D]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/scramble_move_generator_if.sv
`default_nettype none
// ============================================================================
//  Module   : scramble_move_generator_if
//  Purpose  : Request/move handshake bundle between the puzzle controller,
//             the move generator and the move-execution datapath.
//  Revision : 1.0 - initial release
// ============================================================================
interface scramble_move_generator_if #(
  parameter int MOVE_W = 3
);
  logic              RandomPlease;
  logic              MoveReady;
  logic              MoveValid;
  logic [MOVE_W-1:0] MoveCode;
  logic              Busy;
  logic              Done;

  // master: the generator producing moves
  modport master (
    input  RandomPlease,
    input  MoveReady,
    output MoveValid,
    output MoveCode,
    output Busy,
    output Done
  );

  // slave: requester / move consumer side
  modport slave (
    output RandomPlease,
    output MoveReady,
    input  MoveValid,
    input  MoveCode,
    input  Busy,
    input  Done
  );
endinterface
`default_nettype wire

// File: rtl/scramble_move_generator_lfsr16.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr16
//  Purpose  : 16-bit Fibonacci LFSR with load, step enable and zero lockout
//             recovery (an all-zero state reloads SEED on the next cycle).
//  Revision : 1.0 - initial release
// ============================================================================
module lfsr16
  import scramble_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  wire               clk,
  input  wire               rst_n,
  input  wire               load,
  input  wire  [LFSR_W-1:0] load_val,
  input  wire               step,
  output logic [LFSR_W-1:0] value
);

  logic [LFSR_W-1:0] r_value;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_value <= SEED;
    end else if (load) begin
      r_value <= load_val;
    end else if (r_value == '0) begin
      r_value <= SEED;
    end else if (step) begin
      r_value <= lfsrNext(r_value);
    end
  end

  assign value = r_value;

endmodule
`default_nettype wire

// File: rtl/scramble_move_generator.sv
`default_nettype none
// ============================================================================
//  Module   : scramble_move_generator
//  Purpose  : Emits RAND_NUM legal, non-repeating move codes per RandomPlease
//             edge over a valid/ready handshake, then pulses Done.
//  Options  : SCRAMBLE_FREERUN_SEED_EN - reseed the LFSR from a free-running
//             counter at the start of every sequence.
//  Revision : 1.0 - initial release
// ============================================================================
module scramble_move_generator
  import scramble_pkg::*;
#(
  parameter int                RAND_NUM  = 31,
  parameter int                MOVE_W    = 3,
  parameter int                NUM_MOVES = 6,
  parameter logic [LFSR_W-1:0] SEED      = 16'hACE1
) (
  input wire                        clk,
  input wire                        rst_n,
  scramble_move_generator_if.master bus
);

  localparam int                CNT_W    = $clog2(RAND_NUM + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(RAND_NUM - 1);
  localparam logic [MOVE_W:0]   NUM_LIM  = (MOVE_W + 1)'(NUM_MOVES);

  state_t            r_state;
  state_t            w_nextState;

  logic              r_moveValid;
  logic [MOVE_W-1:0] r_moveCode;
  logic [CNT_W-1:0]  r_count;
  logic [MOVE_W-1:0] r_prevMove;
  logic              r_prevValid;
  logic              r_reqArmed;

  logic              w_reqEdge;
  logic              w_startSeq;
  logic              w_accept;
  logic              w_xfer;
  logic              w_busy;
  logic              w_done;
  logic              w_candOk;
  logic [MOVE_W-1:0] w_cand;

  logic              w_lfsrLoad;
  logic [LFSR_W-1:0] w_lfsrLoadVal;
  logic              w_lfsrStep;
  logic [LFSR_W-1:0] w_lfsr;
  logic              w_unusedLfsrHi;

  // ---------------------------------------------------------------- LFSR
  lfsr16 #(
    .SEED     (SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_lfsrLoad),
    .load_val (w_lfsrLoadVal),
    .step     (w_lfsrStep),
    .value    (w_lfsr)
  );

  assign w_lfsrStep = (r_state == GEN);

`ifdef SCRAMBLE_FREERUN_SEED_EN
  logic [LFSR_W-1:0] r_freeCnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_freeCnt <= '0;
    end else begin
      r_freeCnt <= r_freeCnt + LFSR_W'(1);
    end
  end

  assign w_lfsrLoad    = w_startSeq;
  assign w_lfsrLoadVal = (r_freeCnt == '0) ? SEED : r_freeCnt;
`else
  assign w_lfsrLoad    = 1'b0;
  assign w_lfsrLoadVal = SEED;
`endif

  // Upper LFSR bits only feed the shift chain.
  assign w_unusedLfsrHi = ^w_lfsr[LFSR_W-1:MOVE_W];

  // ---------------------------------------------------------------- candidate
  assign w_cand   = w_lfsr[MOVE_W-1:0];
  assign w_candOk = ({1'b0, w_cand} < NUM_LIM) &&
                    !(r_prevValid && (w_cand == r_prevMove));

  // A request held high through reset must drop before it can start anything.
  assign w_reqEdge = bus.RandomPlease && r_reqArmed;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_startSeq  = 1'b0;
    w_accept    = 1'b0;
    w_xfer      = 1'b0;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (w_reqEdge) begin
          w_nextState = START;
        end
      end
      START: begin
        w_startSeq  = 1'b1;
        w_nextState = GEN;
      end
      GEN: begin
        if (w_candOk) begin
          w_accept    = 1'b1;
          w_nextState = HOLD;
        end
      end
      HOLD: begin
        if (r_moveValid && bus.MoveReady) begin
          w_xfer      = 1'b1;
          w_nextState = (r_count == LAST_CNT) ? DONE : GEN;
        end
      end
      DONE: begin
        w_done      = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_busy      = 1'b0;
        w_nextState = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_moveValid <= 1'b0;
      r_moveCode  <= '0;
      r_count     <= '0;
      r_prevMove  <= '0;
      r_prevValid <= 1'b0;
      r_reqArmed  <= 1'b0;
    end else begin
      r_reqArmed <= !bus.RandomPlease;
      if (w_startSeq) begin
        r_count     <= '0;
        r_prevValid <= 1'b0;
      end
      if (w_accept) begin
        r_moveCode  <= w_cand;
        r_moveValid <= 1'b1;
      end
      if (w_xfer) begin
        r_moveValid <= 1'b0;
        r_count     <= r_count + CNT_W'(1);
        r_prevMove  <= r_moveCode;
        r_prevValid <= 1'b1;
      end
    end
  end

  assign bus.MoveValid = r_moveValid;
  assign bus.MoveCode  = r_moveCode;
  assign bus.Busy      = w_busy;
  assign bus.Done      = w_done;

endmodule
`default_nettype wire

// File: tb/tb_scramble_move_generator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scramble_move_generator
//  Purpose  : Self-checking bench: two generators (6 and 5 legal codes) run the
//             same directed stimulus against a cycle-level behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_scramble_move_generator;

  localparam int RAND = 31;
  localparam int SEED_V = 32'hACE1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scramble_move_generator_if #(.MOVE_W(3)) bus6 ();
  scramble_move_generator_if #(.MOVE_W(3)) bus5 ();

  scramble_move_generator #(.RAND_NUM(RAND), .MOVE_W(3), .NUM_MOVES(6), .SEED(16'hACE1)) dut6 (
    .clk(clk), .rst_n(rst_n), .bus(bus6)
  );
  scramble_move_generator #(.RAND_NUM(RAND), .MOVE_W(3), .NUM_MOVES(5), .SEED(16'hACE1)) dut5 (
    .clk(clk), .rst_n(rst_n), .bus(bus5)
  );

  int nCmp = 0;
  int nFail = 0;

  task automatic check(input string name, input int act, input int exp);
    nCmp++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ----------------------------------------------------------- model state
  int numMoves[2] = '{6, 5};
  int ph[2]       = '{0, 0};      // 0 idle, 1 waiting for valid, 2 valid, 3 done pulse
  int validAt[2]  = '{0, 0};
  int mCount[2]   = '{0, 0};
  int mLfsr[2]    = '{SEED_V, SEED_V};
  int mPrev[2]    = '{0, 0};
  int mPrevV[2]   = '{0, 0};
  int mArmed[2]   = '{0, 0};
  int mCode[2]    = '{0, 0};
  int rstChk[2]   = '{0, 0};
  int xfer[2]     = '{0, 0};
  int dones[2]    = '{0, 0};
  int startCyc[2] = '{0, 0};
  int firstLat[2] = '{-1, -1};
  int lastAct[2]  = '{0, 0};
  int logCode[2][64];
  int refCode[2][64];
  int cyc = 0;
  bit live = 1'b0;

  // Draw candidates from the low three LFSR bits until a legal one appears.
  task automatic genMove(input int d, output int c, output int rej);
    int l;
    int fb;
    bit ok;
    l = mLfsr[d];
    rej = 0;
    ok = 1'b0;
    c = 0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      c = l % 8;
      fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
      l = ((l << 1) | fb) & 32'hFFFF;
      if (c < numMoves[d] && !(mPrevV[d] != 0 && c == mPrev[d])) ok = 1'b1;
      else rej++;
    end
    mLfsr[d] = l;
  endtask

  // ----------------------------------------------------------- compare process
  always @(negedge clk) begin
    int v, b, dn, rq, rd, cd, nc, r;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin
        v = int'(bus6.MoveValid); b = int'(bus6.Busy); dn = int'(bus6.Done);
        rq = int'(bus6.RandomPlease); rd = int'(bus6.MoveReady); cd = int'(bus6.MoveCode);
      end else begin
        v = int'(bus5.MoveValid); b = int'(bus5.Busy); dn = int'(bus5.Done);
        rq = int'(bus5.RandomPlease); rd = int'(bus5.MoveReady); cd = int'(bus5.MoveCode);
      end
      if (live) begin
        if (ph[d] == 1 && cyc >= validAt[d]) ph[d] = 2;
        check("busy", b, int'(ph[d] != 0));
        check("valid", v, int'(ph[d] == 2));
        check("done", dn, int'(ph[d] == 3));
        if (ph[d] == 2) check("code", cd, mCode[d]);
        if (rstChk[d] != 0) check("code_after_reset", cd, 0);
        if (v != 0 && firstLat[d] < 0) firstLat[d] = cyc - startCyc[d];
        if (v != 0 && rd != 0) begin
          check("code_range", int'(cd < numMoves[d]), 1);
          if (xfer[d] > 0) check("no_repeat", int'(cd != lastAct[d]), 1);
          if (xfer[d] < 64) logCode[d][xfer[d]] = cd;
          xfer[d]++;
          lastAct[d] = cd;
        end
        if (dn != 0) begin
          dones[d]++;
          check("xfers_at_done", xfer[d], RAND);
        end
      end
      rstChk[d] = 0;
      if (rst_n == 1'b0) begin
        ph[d] = 0; mLfsr[d] = SEED_V; mArmed[d] = 0; mPrevV[d] = 0; rstChk[d] = 1;
      end else begin
        case (ph[d])
          0: if (rq != 0 && mArmed[d] != 0) begin
               ph[d] = 1; mPrevV[d] = 0; mCount[d] = 0; xfer[d] = 0;
               startCyc[d] = cyc; firstLat[d] = -1;
               genMove(d, nc, r);
               mCode[d] = nc; validAt[d] = cyc + 3 + r;
             end
          2: if (rd != 0) begin
               mCount[d]++; mPrev[d] = mCode[d]; mPrevV[d] = 1;
               if (mCount[d] == RAND) ph[d] = 3;
               else begin
                 genMove(d, nc, r);
                 mCode[d] = nc; validAt[d] = cyc + 2 + r; ph[d] = 1;
               end
             end
          3: ph[d] = 0;
          default: ;
        endcase
        mArmed[d] = int'(rq == 0);
      end
    end
    if (rst_n == 1'b0) live = 1'b1;
  end

  // ----------------------------------------------------------- stimulus helpers
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic setReq(input bit val);
    bus6.RandomPlease = val;
    bus5.RandomPlease = val;
  endtask

  task automatic setReady(input bit val);
    bus6.MoveReady = val;
    bus5.MoveReady = val;
  endtask

  task automatic startReq();
    setReq(1'b0);
    tick();
    setReq(1'b1);
    tick();
  endtask

  task automatic waitXfer(input int n);
    int t = 0;
    while (xfer[0] < n && t < 2000) begin
      tick();
      t++;
    end
    if (xfer[0] < n) check("wait_xfer_timeout", xfer[0], n);
  endtask

  task automatic waitIdle();
    int t = 0;
    tick(2);
    while ((bus6.Busy || bus5.Busy) && t < 3000) begin
      tick();
      t++;
    end
    if (bus6.Busy || bus5.Busy) check("wait_idle_timeout", 1, 0);
  endtask

  // ----------------------------------------------------------- directed stimulus
  initial begin
    int hold;
    int t;
    int exp4[4];
    exp4[0] = 1; exp4[1] = 3; exp4[2] = 4; exp4[3] = 1;
    rst_n = 1'b0;
    setReq(1'b1);
    setReady(1'b1);
    tick(3);
    rst_n = 1'b1;
    tick(5);
    check("held_req_no_start6", int'(bus6.Busy), 0);
    check("held_req_no_start5", int'(bus5.Busy), 0);

    // Sequence 1: plain run, ready always high
    startReq();
    waitIdle();
    check("seq1_dones6", dones[0], 1);
    check("seq1_dones5", dones[1], 1);
    check("first_latency6", firstLat[0], 3);
    check("first_latency5", firstLat[1], 3);
    for (int i = 0; i < 4; i++) begin
      check("seed_code6", logCode[0][i], exp4[i]);
      check("seed_code5", logCode[1][i], exp4[i]);
    end
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < RAND; i++) refCode[d][i] = logCode[d][i];

    // Sequence 2: backpressure and an ignored second request edge
    startReq();
    waitXfer(5);
    t = 0;
    while (!bus6.MoveValid && t < 100) begin
      tick();
      t++;
    end
    check("bp_found_valid", int'(bus6.MoveValid), 1);
    hold = int'(bus6.MoveCode);
    setReady(1'b0);
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", int'(bus6.MoveValid), 1);
      check("bp_code", int'(bus6.MoveCode), hold);
      @(posedge clk);
      #2;
    end
    setReady(1'b1);
    waitXfer(10);
    startReq();
    waitIdle();
    check("seq2_dones6", dones[0], 2);
    check("seq2_dones5", dones[1], 2);

    // Sequence 3: reset after 10 transfers, request held across the reset
    startReq();
    waitXfer(10);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_reset_valid", int'(bus6.MoveValid), 0);
    check("mid_reset_busy", int'(bus6.Busy), 0);
    tick(4);
    check("mid_reset_no_restart", int'(bus6.Busy), 0);
    check("mid_reset_no_done", dones[0], 2);

    // Sequence 4: must replay sequence 1 exactly
    startReq();
    waitIdle();
    check("seq4_dones6", dones[0], 3);
    check("seq4_dones5", dones[1], 3);
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < RAND; i++)
        check("replay_code", logCode[d][i], refCode[d][i]);

    tick(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
